// File: rtl/panda_pkg.sv
// Shared types for the panda execute stage: divider operator and FSM state.
package panda_pkg;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'd0,
    DIV_DIVU = 2'd1,
    DIV_REM  = 2'd2,
    DIV_REMU = 2'd3
  } div_operator_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/panda_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; Width+2 cycles (special cases 1).
// No output back-pressure: valid_o is a one-cycle pulse; ready_o is low while busy.
module panda_divider
  import panda_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             kill_i,
  input  div_operator_e    operator_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  output logic             valid_o,
  output logic [Width-1:0] result_o
);

  localparam int CntW = $clog2(Width);
  localparam logic [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};

  div_state_e       state_q, state_d;
  div_operator_e    op_q, op_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [Width-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             accept, signed_op, is_div_in, a_neg, b_neg, div_by_zero, overflow;
  logic [Width-1:0] abs_a, abs_b;
  logic [Width:0]   shifted, trial;

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

  assign accept      = valid_i && ready_o && !kill_i;
  assign signed_op   = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
  assign is_div_in   = (operator_i == DIV_DIV) || (operator_i == DIV_DIVU);
  assign a_neg       = signed_op && operand_a_i[Width-1];
  assign b_neg       = signed_op && operand_b_i[Width-1];
  assign abs_a       = a_neg ? -operand_a_i : operand_a_i;
  assign abs_b       = b_neg ? -operand_b_i : operand_b_i;
  assign div_by_zero = (operand_b_i == '0);
  assign overflow    = signed_op && (operand_a_i == MinVal) && (operand_b_i == '1);

  // Partial remainder is always below the divisor, so Width+1 bits hold the shifted value.
  assign shifted = {rem_q, quo_q[Width-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_d     = operator_i;
            sign_a_d = a_neg;
            sign_b_d = b_neg;
            dvs_d    = abs_b;
            if (div_by_zero) begin
              result_d = is_div_in ? '1 : operand_a_i;
              state_d  = DONE;
            end else if (overflow) begin
              result_d = is_div_in ? MinVal : '0;
              state_d  = DONE;
            end else begin
              rem_d   = '0;
              quo_d   = abs_a;
              cnt_d   = CntW'(Width - 1);
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = trial[Width] ? shifted[Width-1:0] : trial[Width-1:0];
          quo_d = {quo_q[Width-2:0], ~trial[Width]};
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == '0) state_d = FIX;
        end
        FIX: begin
          unique case (op_q)
            DIV_DIV:  result_d = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
            DIV_DIVU: result_d = quo_q;
            DIV_REM:  result_d = sign_a_q ? -rem_q : rem_q;
            DIV_REMU: result_d = rem_q;
          endcase
          state_d = DONE;
        end
        DONE: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= DIV_DIV;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule
